// File: rtl/stack_ram_ctrl.sv
// Stack data store: one push/pop per request on an internal RAM, with occupancy and error reporting.
// Latency: done two edges after the request edge; requests arriving while busy are dropped, never queued.
module stack_ram_ctrl #(
    parameter int         WIDTH = 8,
    parameter logic [7:0] BASE  = 8'hB0,
    parameter logic [7:0] TOP   = 8'hFF,
    parameter int         DEPTH = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rw,
    input  logic [7:0]       address,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [6:0]       count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       addr_q;
    logic             rw_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [6:0]       count_q, count_d;
    logic             err_q, err_d;
    logic             latch_req;
    logic             mem_we;
    logic [7:0]       off;
    logic             in_range;
    logic [AW-1:0]    idx;
    logic             full_w, empty_w;

    logic [WIDTH-1:0] mem [DEPTH];

    // Wrapping subtraction folds both range bounds into one unsigned compare.
    assign off      = addr_q - BASE;
    assign in_range = (off <= (TOP - BASE));
    assign idx      = AW'(off);

    assign full_w  = (count_q == 7'(DEPTH));
    assign empty_w = (count_q == 7'd0);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        latch_req = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    latch_req = 1'b1;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                err_d   = 1'b0;
                if (!in_range) begin
                    err_d = 1'b1;
                end else if (!rw_q) begin
                    if (full_w) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + 7'd1;
                    end
                end else begin
                    if (empty_w) begin
                        err_d = 1'b1;
                    end else begin
                        rdata_d = mem[idx];
                        count_d = count_q - 7'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= 7'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= 8'd0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (latch_req) begin
                addr_q  <= address;
                rw_q    <= rw;
                wdata_q <= wdata;
            end
        end
    end

    // RAM contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[idx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign done  = (state_q == S_DONE);
    assign err   = (state_q == S_DONE) && err_q;
    assign busy  = (state_q != S_IDLE);
    assign count = count_q;
    assign full  = full_w;
    assign empty = empty_w;

endmodule

// File: tb/tb_stack_ram_ctrl.sv
// Directed bench for stack_ram_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_stack_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rw;
    logic [7:0] address;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       done;
    logic       busy;
    logic       err;
    logic [6:0] count;
    logic       full;
    logic       empty;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done;
    logic last_err;

    always #5 clk = ~clk;

    stack_ram_ctrl #(
        .WIDTH(8),
        .BASE (8'hB0),
        .TOP  (8'hFF),
        .DEPTH(80)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .rw     (rw),
        .address(address),
        .wdata  (wdata),
        .rdata  (rdata),
        .done   (done),
        .busy   (busy),
        .err    (err),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and returns in its DONE cycle, so count/rdata/err are observable.
    task automatic op(input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        en = 1'b1; rw = r; address = a; wdata = d;
        @(negedge clk);
        en = 1'b0;
        chk("busy_in_access", busy, 1);
        chk("done_too_early", done, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        last_err = err;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rw = 1'b0; address = 8'h00; wdata = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // rst and en together: request dropped
        en = 1'b1; address = 8'hFF; wdata = 8'h77;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        chk("rst_en_busy", busy, 0);
        @(negedge clk);
        chk("rst_en_busy2", busy, 0);
        chk("rst_en_count", count, 0);

        // round trip
        op(1'b0, 8'hFF, 8'hA5);
        chk("push_err", last_err, 0);
        chk("push_count", count, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        op(1'b1, 8'hFF, 8'h00);
        chk("pop_rdata", rdata, 8'hA5);
        chk("pop_count", count, 0);
        chk("pop_err", last_err, 0);

        // fill
        for (int i = 0; i < 80; i++) begin
            op(1'b0, 8'(8'hFF - i), 8'(i));
            chk("fill_err", last_err, 0);
        end
        chk("fill_count", count, 80);
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);

        op(1'b0, 8'hB0, 8'hEE);
        chk("ovf_err", last_err, 1);
        chk("ovf_count", count, 80);
        chk("ovf_rdata", rdata, 8'hA5);

        for (int j = 0; j < 80; j++) begin
            op(1'b1, 8'(8'hB0 + j), 8'h00);
            chk("drain_rdata", rdata, 32'(79 - j));
            chk("drain_err", last_err, 0);
        end
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);
        chk("drain_full", full, 0);

        // underflow keeps the last popped value
        op(1'b0, 8'hFF, 8'h3C);
        op(1'b1, 8'hFF, 8'h00);
        chk("pre_udf_rdata", rdata, 8'h3C);
        op(1'b1, 8'hFF, 8'h00);
        chk("udf_err", last_err, 1);
        chk("udf_rdata", rdata, 8'h3C);
        chk("udf_count", count, 0);

        // out-of-range addresses
        op(1'b0, 8'hAF, 8'h55);
        chk("range_push_err", last_err, 1);
        chk("range_push_count", count, 0);
        op(1'b0, 8'hFF, 8'h66);
        op(1'b1, 8'h00, 8'h00);
        chk("range_pop_err", last_err, 1);
        chk("range_pop_count", count, 1);
        chk("range_pop_rdata", rdata, 8'h3C);
        op(1'b1, 8'hFF, 8'h00);
        chk("range_after_pop", rdata, 8'h66);
        chk("range_after_count", count, 0);

        // en held through ACCESS and DONE: one request only
        n_done = 0;
        @(negedge clk);
        en = 1'b1; rw = 1'b0; address = 8'hFF; wdata = 8'h11;
        @(negedge clk);
        if (done) n_done++;
        @(negedge clk);
        if (done) n_done++;
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("drop_dones", n_done, 1);
        chk("drop_count", count, 1);

        // reset during ACCESS of a push
        @(negedge clk);
        en = 1'b1; rw = 1'b0; address = 8'hFE; wdata = 8'h22;
        @(negedge clk);
        en = 1'b0;
        chk("midop_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop_busy", busy, 0);
        chk("midop_done", done, 0);
        chk("midop_count", count, 0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midop_no_done", n_done, 0);
        chk("midop_count2", count, 0);

        // en held continuously: one accept per IDLE cycle
        n_done = 0;
        en = 1'b1; rw = 1'b0; address = 8'hFF; wdata = 8'h44;
        repeat (9) begin
            @(negedge clk);
            if (done) n_done++;
        end
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("stream_dones", n_done, 3);
        chk("stream_count", count, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
